// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming K x K max-pooling over an ARRAY_WIDTH x ARRAY_WIDTH
// signed feature map delivered one pixel per cycle in raster order. Uses K-1
// line buffers for the vertical max and a short shift register of previous
// column maxima for the horizontal max, so no frame storage is needed.
// Optional feature: define MAXPOOL_RELU_EN to clamp negative results to zero.
module maxpool_stream #(
    parameter int DATA_WIDTH       = 8,
    parameter int ARRAY_WIDTH      = 3,
    parameter int POOL_FILTER_SIZE = 2,
    parameter int POOL_STRIDE      = 1,
    parameter int RESULT_WIDTH     = ((ARRAY_WIDTH - POOL_FILTER_SIZE) / POOL_STRIDE) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  frame_done
);

    localparam int K        = POOL_FILTER_SIZE;
    localparam int CW       = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1;
    // Row/column of the final emitting window corner in a frame.
    localparam int LAST_POS = (K - 1) + (RESULT_WIDTH - 1) * POOL_STRIDE;

    localparam logic [CW-1:0] LAST_IDX   = CW'(ARRAY_WIDTH - 1);
    localparam logic [CW-1:0] FILL_ROW   = CW'(K - 2);
    localparam logic [CW-1:0] LAST_POS_C = CW'(LAST_POS);

    typedef enum logic {
        FILL,
        POOL
    } state_t;

    state_t state, state_next;

    logic [CW-1:0] col, row;
    logic          accept, emit;

    // line_buf[0] holds the oldest buffered row, line_buf[K-2] the newest.
    logic signed [DATA_WIDTH-1:0] line_buf [K-1][ARRAY_WIDTH];
    // Previous K-1 column maxima; together with the current col_max they form
    // the K-wide horizontal window.
    logic signed [DATA_WIDTH-1:0] hist [K-1];

    logic signed [DATA_WIDTH-1:0] col_max, pool_max, result;

    function automatic logic signed [DATA_WIDTH-1:0] smax(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // True when a row/column index is a window corner: past the first K-1
    // positions and aligned to the stride.
    function automatic logic on_grid(input logic [CW-1:0] p);
        int off;
        off = int'(p) - (K - 1);
        return (off >= 0) && ((off % POOL_STRIDE) == 0);
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign emit     = accept && (state == POOL) && on_grid(row) && on_grid(col);

    // Vertical max of the incoming pixel and the buffered pixels above it.
    always_comb begin
        // NOTE: assign a default before any conditional update so always_comb never infers a latch.
        col_max = in_data;
        for (int i = 0; i < K - 1; i++) begin
            col_max = smax(col_max, line_buf[i][col]);
        end
    end

    // Horizontal max over the current column max and the previous K-1.
    always_comb begin
        pool_max = col_max;
        for (int i = 0; i < K - 1; i++) begin
            pool_max = smax(pool_max, hist[i]);
        end
    end

`ifdef MAXPOOL_RELU_EN
    // Fused ReLU: any negative pooled value is clamped to zero.
    assign result = pool_max[DATA_WIDTH-1] ? '0 : pool_max;
`else
    assign result = pool_max;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: FILL until the first K-1 rows are buffered, POOL to frame end.
    always_comb begin
        state_next = state;
        case (state)
            FILL: if (accept && row == FILL_ROW && col == LAST_IDX) state_next = POOL;
            POOL: if (accept && row == LAST_IDX && col == LAST_IDX) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Raster position counters; wrap to (0,0) after the last pixel of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == LAST_IDX) begin
                col <= '0;
                row <= (row == LAST_IDX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Shift the line buffers vertically at this column and the column-max history horizontally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: these buffers are small register arrays, so clearing them in reset is cheap;
            // a RAM-based buffer would be left unreset because FILL masks stale contents anyway.
            for (int i = 0; i < K - 1; i++) begin
                for (int j = 0; j < ARRAY_WIDTH; j++) begin
                    line_buf[i][j] <= '0;
                end
                hist[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < K - 2; i++) begin
                line_buf[i][col] <= line_buf[i+1][col];
                hist[i]          <= hist[i+1];
            end
            line_buf[K-2][col] <= in_data;
            hist[K-2]          <= col_max;
        end
    end

    // Single-entry output register plus the frame_done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid && out_ready && out_last;
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_last  <= (row == LAST_POS_C) && (col == LAST_POS_C);
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/maxpool_stream.md
# maxpool_stream

Streaming max-pooling stage that consumes the convolution engine's output feature map one pixel per cycle in raster order and produces the pooled result map in raster order. It sits directly downstream of the convolution stage and upstream of the fully connected layer. Geometry comes from the shared `yolo_params_pkg` defaults (3×3 input, 2×2 window, stride 1, 2×2 result). Internally it uses K−1 line buffers plus a K-wide column-max shift register, so no frame storage is needed.

## Interface
Parameters:
- DATA_WIDTH, 8 — pixel width; signed two's complement.
- ARRAY_WIDTH, 3 — input map is ARRAY_WIDTH×ARRAY_WIDTH.
- POOL_FILTER_SIZE, 2 — window K; legal range 2..ARRAY_WIDTH.
- POOL_STRIDE, 1 — stride S ≥ 1.
- RESULT_WIDTH, ((ARRAY_WIDTH−POOL_FILTER_SIZE)/POOL_STRIDE)+1 — derived; never overridden.

Ports:
- clk  in  1  clock. One clock domain; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  stage can accept a pixel.
- in_data  in  DATA_WIDTH  input pixel.
- out_valid  out  1  pooled result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_WIDTH  pooled maximum.
- out_last  out  1  qualifies the final result of a frame.
- frame_done  out  1  one-cycle pulse when the final result of a frame is accepted.

## Operation
- **Input accept.** A pixel is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational).
- **Counters.** Column counter col and row counter row, each 0..ARRAY_WIDTH−1.
  - col advances on every accepted pixel and wraps at ARRAY_WIDTH−1.
  - row advances when col wraps.
  - Both wrap to 0 after pixel ARRAY_WIDTH²−1, so the next frame starts immediately.
- **Line buffers.** K−1 row buffers, each ARRAY_WIDTH deep, indexed by col. On accept:
  - colmax = signed max of in_data and the K−1 buffered values at col.
  - Buffers shift vertically: newest row gets in_data.
  - colmax is shifted into a K-entry horizontal register.
- **Emit condition.** A result is produced on the accept of pixel (row, col) when all of the following hold:
  - row ≥ K−1 and col ≥ K−1;
  - (row−K+1) mod S == 0;
  - (col−K+1) mod S == 0.
  - The result is the signed max of the K horizontal entries (the current colmax plus the previous K−1).
- **Comparisons.** All comparisons are signed, DATA_WIDTH wide, with no widening. Ties yield that value.
- **FSM.**
  - FILL: row < K−1; no output is possible. Moves to POOL when accepting the last pixel of row K−2.
  - POOL: emits per the emit condition. Returns to FILL when accepting pixel ARRAY_WIDTH²−1.
  - Reset state is FILL.
- **out_last.** Asserted with the result at row = col = last emitting position, i.e. result index RESULT_WIDTH²−1.
- **frame_done.** Pulses the cycle after the out_valid && out_ready && out_last handshake.

## Timing
- **Reset values.** out_valid=0, out_data=0, out_last=0, frame_done=0, row=col=0, state FILL, horizontal register and line buffers cleared. in_ready=1 while rst is high, since out_valid=0.
- **Latency.** out_valid rises the cycle after the accept of the window-completing pixel.
- **Throughput.** With out_ready held high, one pixel per cycle is sustained.
- **Output register.** Single entry.
  - out_valid, out_data and out_last hold stable while out_valid && !out_ready.
  - in_ready is low in that condition, so no pixel is lost or overwritten.
- **Simultaneous events.** An output handshake together with a new emitting accept in the same cycle reloads the register and keeps out_valid high. A non-emitting accept in that cycle clears out_valid.
- **Frame boundary.** Pixel 0 of the next frame may be accepted in the cycle right after pixel ARRAY_WIDTH²−1, subject to in_ready. Line buffer contents from the previous frame are don't-care, because FILL masks them.
- **Mid-frame reset.** rst asserted mid-frame aborts the frame immediately. The partial frame is discarded. The first pixel after release is treated as (0,0).
- **in_valid low.** The counters hold and there is no state change.

## Configuration
- **MAXPOOL_RELU_EN defined:** fused ReLU. A pooled result with the sign bit set is output as 0. Latency and handshake are unchanged.
- **MAXPOOL_RELU_EN undefined:** the raw signed maximum is output.

## Test plan
- **Basic frame.** Defaults, inputs 1..9, out_ready=1 → outputs 5,6,8,9 on consecutive emitting cycles. out_last with 9. frame_done one cycle after 9 is accepted.
- **Negative values.** Defaults, inputs −9..−1 → outputs −5,−4,−2,−1. With MAXPOOL_RELU_EN defined → 0,0,0,0.
- **Backpressure.** Defaults, inputs 1..9, out_ready low for 3 cycles while 5 is pending → 5 held stable, in_ready=0 during the stall, sequence 5,6,8,9 intact with no drops.
- **Stride and size.** ARRAY_WIDTH=4, K=2, S=2, inputs 1..16 → outputs 6,8,14,16. out_last on 16. No output at odd window offsets.
- **Back-to-back frames.** Defaults, frames 1..9 then 10..18 with no gap → 5,6,8,9,14,15,17,18. Two frame_done pulses. No cross-frame contamination.
- **Mid-frame reset.** Assert rst after the 5th pixel, then send 1..9 → all outputs zero during reset, then exactly 5,6,8,9.
